// File: rtl/wb_led_walker_pkg.sv
// wb_led_walker_pkg: shared constants for the LED walker slave.
//   - register addresses on the 2-bit Wishbone address bus
//   - CTRL mode encodings
//   - walk state enum
package wb_led_walker_pkg;

  localparam logic [1:0] ADDR_CTRL  = 2'd0;
  localparam logic [1:0] ADDR_RATE  = 2'd1;
  localparam logic [1:0] ADDR_LED   = 2'd2;
  localparam logic [1:0] ADDR_COUNT = 2'd3;

  localparam logic [1:0] MODE_BOUNCE = 2'd0;  // there and back, once
  localparam logic [1:0] MODE_ONEWAY = 2'd1;  // forward only, once
  localparam logic [1:0] MODE_CONT   = 2'd2;  // bounce forever
  localparam logic [1:0] MODE_STOP   = 2'd3;  // halt and blank

  typedef enum logic [1:0] {IDLE, FWD, REV} walk_state_e;

endpackage

// File: rtl/wb_led_walker_if.sv
// wb_led_walker_if: pipelined Wishbone slave bus for the LED walker.
//   i_cyc/i_stb/i_we/i_addr/i_data : request from master
//   o_stall/o_ack/o_data           : response from slave
interface wb_led_walker_if;
  logic        i_cyc;
  logic        i_stb;
  logic        i_we;
  logic [1:0]  i_addr;
  logic [31:0] i_data;
  logic        o_stall;
  logic        o_ack;
  logic [31:0] o_data;

  modport master (output i_cyc, i_stb, i_we, i_addr, i_data,
                  input  o_stall, o_ack, o_data);
  modport slave  (input  i_cyc, i_stb, i_we, i_addr, i_data,
                  output o_stall, o_ack, o_data);
endinterface

// File: rtl/wb_led_walker_prescaler.sv
// walk_prescaler: step-rate divider for the LED walker.
//   i_clk, i_reset_n : clock, async active-low reset
//   i_clear          : restart the count at 0 (walk (re)start)
//   i_enable         : count only while the walker is busy
//   i_rate           : clocks per step minus 1
//   o_tick           : one-cycle step pulse
// The >= compare lets a RATE lowered below the current count fire on the
// next enabled cycle instead of wrapping the whole counter.
module walk_prescaler #(
  parameter int RATE_W = 24
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_clear,
  input  logic              i_enable,
  input  logic [RATE_W-1:0] i_rate,
  output logic              o_tick
);

  logic [RATE_W-1:0] cnt;

  assign o_tick = i_enable & (cnt >= i_rate);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)            cnt <= '0;
    else if (i_clear | o_tick) cnt <= '0;
    else if (i_enable)         cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/wb_led_walker.sv
// wb_led_walker: Wishbone (pipelined) slave walking one lit LED over NLEDS.
//   i_clk, i_reset_n : clock, async active-low reset
//   bus              : Wishbone slave (CTRL/RATE/LED/COUNT registers)
//   o_led            : LED drive, one-hot while walking, else zero or a
//                      value written through the LED register
module wb_led_walker
  import wb_led_walker_pkg::*;
#(
  parameter int                NLEDS        = 8,
  parameter int                RATE_W       = 24,
  parameter logic [RATE_W-1:0] DEFAULT_RATE = '0
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  wb_led_walker_if.slave   bus,
  output logic [NLEDS-1:0] o_led
);

  localparam int            PW   = $clog2(NLEDS);
  localparam logic [PW-1:0] LAST = PW'(NLEDS - 1);

  walk_state_e       state_q, state_d;
  logic [PW-1:0]     pos_q, pos_d;
  logic [NLEDS-1:0]  led_q, led_d;
  logic [1:0]        mode_q;
  logic [RATE_W-1:0] rate_q;
  logic [15:0]       count_q;
  logic              ack_q;
  logic [31:0]       data_q, rd_data;
  logic              busy, tick, pass_done, acc, wr, start;
  logic              wr_ctrl, wr_rate, wr_led, wr_count;
  logic              unused_data;

  assign unused_data = ^bus.i_data;

  assign busy        = (state_q != IDLE);
  // LED writes would fight the walk, so they wait until idle.
  assign bus.o_stall = busy & bus.i_we & (bus.i_addr == ADDR_LED);
  assign acc         = bus.i_cyc & bus.i_stb & ~bus.o_stall;
  assign wr          = acc & bus.i_we;
  assign wr_ctrl     = wr & (bus.i_addr == ADDR_CTRL);
  assign wr_rate     = wr & (bus.i_addr == ADDR_RATE);
  assign wr_led      = wr & (bus.i_addr == ADDR_LED);
  assign wr_count    = wr & (bus.i_addr == ADDR_COUNT);
  assign start       = wr_ctrl & (bus.i_data[1:0] != MODE_STOP);

  assign bus.o_ack   = ack_q;
  assign bus.o_data  = data_q;
  assign o_led       = led_q;

  walk_prescaler #(.RATE_W(RATE_W)) u_presc (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_clear  (start),
    .i_enable (busy),
    .i_rate   (rate_q),
    .o_tick   (tick)
  );

  // Next-state: a CTRL write overrides any tick in the same cycle.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    led_d     = led_q;
    pass_done = 1'b0;
    if (wr_ctrl) begin
      if (start) begin
        state_d = FWD;
        pos_d   = '0;
        led_d   = NLEDS'(1);
      end else begin
        state_d = IDLE;
        led_d   = '0;
      end
    end else if (wr_led) begin
      led_d = bus.i_data[NLEDS-1:0];
    end else if (tick) begin
      unique case (state_q)
        FWD: begin
          if (pos_q != LAST)             pos_d = pos_q + 1'b1;
          else if (mode_q == MODE_ONEWAY) begin
            state_d   = IDLE;
            pass_done = 1'b1;
          end else begin
            state_d = REV;
            pos_d   = pos_q - 1'b1;
          end
        end
        REV: begin
          if (pos_q != '0) pos_d = pos_q - 1'b1;
          else begin
            pass_done = 1'b1;
            // Continuous mode resumes at 1 so the end LED is not lit twice.
            if (mode_q == MODE_CONT) begin
              state_d = FWD;
              pos_d   = PW'(1);
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: ;
      endcase
      led_d = (state_d == IDLE) ? '0 : (NLEDS'(1) << pos_d);
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (bus.i_addr)
      ADDR_CTRL:  rd_data = {29'b0, busy, mode_q};
      ADDR_RATE:  rd_data = 32'(rate_q);
      ADDR_LED:   rd_data = 32'(led_q);
      ADDR_COUNT: rd_data = {16'b0, count_q};
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      pos_q   <= '0;
      led_q   <= '0;
      mode_q  <= MODE_BOUNCE;
      rate_q  <= DEFAULT_RATE;
      count_q <= '0;
      ack_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      led_q   <= led_d;
      ack_q   <= acc;
      if (acc)      data_q  <= rd_data;
      if (wr_ctrl)  mode_q  <= bus.i_data[1:0];
      if (wr_rate)  rate_q  <= bus.i_data[RATE_W-1:0];
      // Clear beats a pass completing in the same cycle.
      if (wr_count)       count_q <= '0;
      else if (pass_done) count_q <= count_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_wb_led_walker.sv
module tb_wb_led_walker;
  import wb_led_walker_pkg::*;

  localparam int N    = 6;
  localparam int RW   = 8;
  localparam int DEFR = 2;

  logic         i_clk = 1'b0;
  logic         i_reset_n = 1'b0;
  logic [N-1:0] o_led;

  wb_led_walker_if bus();

  wb_led_walker #(.NLEDS(N), .RATE_W(RW), .DEFAULT_RATE(RW'(DEFR))) dut (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .bus      (bus),
    .o_led    (o_led)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic         ack;
    logic         rd;
    logic [31:0]  data;
    logic [N-1:0] led;
    logic         busy;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: the walk is a list of LED positions, -1 marks the end
  // of a pass; each position is held until RATE+1 cycles have elapsed.
  bit           m_busy;
  int           m_mode, m_rate, m_held, m_cur, m_count;
  logic [N-1:0] m_led;
  int           m_path[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
    end
  endfunction

  function automatic void m_reset();
    m_busy = 0; m_mode = 0; m_rate = DEFR; m_held = 0; m_cur = 0;
    m_count = 0; m_led = '0; m_path.delete();
  endfunction

  function automatic void push_pass(int first);
    for (int p = first; p < N; p++) m_path.push_back(p);
    if (m_mode != 1) for (int p = N - 2; p >= 0; p--) m_path.push_back(p);
    m_path.push_back(-1);
  endfunction

  function automatic void m_start();
    m_path.delete();
    push_pass(0);
    m_cur  = m_path.pop_front();
    m_busy = 1; m_held = 0;
    m_led  = N'(1) << m_cur;
  endfunction

  function automatic bit m_step();
    int nxt;
    if (m_held < m_rate) begin m_held++; return 0; end
    m_held = 0;
    nxt = m_path.pop_front();
    if (nxt < 0) begin
      if (m_mode == 2) begin
        push_pass(1);
        nxt = m_path.pop_front();
      end else begin
        m_busy = 0; m_led = '0;
        return 1;
      end
      m_cur = nxt; m_led = N'(1) << m_cur;
      return 1;
    end
    m_cur = nxt; m_led = N'(1) << m_cur;
    return 0;
  endfunction

  // Predictor: at each edge, apply what the DUT samples and queue the
  // response expected in the following cycle.
  always @(posedge i_clk) begin : pred
    exp_t e;
    bit acc, pass, we;
    logic [1:0] a;
    if (!i_reset_n) begin
      m_reset();
      exp_q.delete();
      e.ack = 0; e.rd = 0; e.data = '0; e.led = '0; e.busy = 0;
      exp_q.push_back(e);
    end else begin
      a = bus.i_addr; we = bus.i_we;
      acc = bus.i_cyc && bus.i_stb && !(m_busy && we && a == 2'd2);
      e.ack = acc; e.rd = acc && !we; e.data = '0;
      if (e.rd) begin
        case (a)
          2'd0: e.data = {29'b0, m_busy, m_mode[1:0]};
          2'd1: e.data = 32'(m_rate);
          2'd2: e.data = 32'(m_led);
          default: e.data = 32'(m_count);
        endcase
      end
      pass = 0;
      if (acc && we && a == 2'd0) begin
        m_mode = int'(bus.i_data[1:0]);
        if (m_mode == 3) begin m_busy = 0; m_led = '0; m_path.delete(); end
        else m_start();
      end else if (m_busy) begin
        pass = m_step();
      end
      if (acc && we && a == 2'd3) m_count = 0;
      else if (pass)              m_count = (m_count + 1) & 16'hFFFF;
      if (acc && we && a == 2'd1) m_rate = int'(bus.i_data[RW-1:0]);
      if (acc && we && a == 2'd2) m_led = bus.i_data[N-1:0];
      e.led = m_led; e.busy = m_busy;
      exp_q.push_back(e);
    end
  end

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge i_clk) begin : mon
    exp_t e;
    if (i_reset_n) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard_empty t=%0t got=none expected=entry", $time);
      end else begin
        e = exp_q.pop_front();
        chk("ack", 32'(bus.o_ack), 32'(e.ack));
        if (e.rd && bus.o_ack) chk("rdata", bus.o_data, e.data);
        chk("led", 32'(o_led), 32'(e.led));
        chk("stall", 32'(bus.o_stall),
            32'(e.busy && bus.i_we && bus.i_addr == 2'd2));
      end
    end
  end

  task automatic idle(int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic req(bit we, logic [1:0] a, logic [31:0] d, bit keep = 0);
    int  w = 0;
    bit  st;
    bus.i_cyc = 1; bus.i_stb = 1; bus.i_we = we; bus.i_addr = a; bus.i_data = d;
    forever begin
      @(negedge i_clk); st = bus.o_stall;
      @(posedge i_clk); #1;
      if (!st) break;
      w++;
      if (w >= 500) begin
        checks++; failures++;
        $display("FAIL stall_timeout t=%0t got=stalled expected=accept", $time);
        break;
      end
    end
    if (!keep) begin bus.i_cyc = 0; bus.i_stb = 0; bus.i_we = 0; end
  endtask

  task automatic read_all();
    req(0, ADDR_CTRL, 0, 1); req(0, ADDR_RATE, 0, 1);
    req(0, ADDR_LED, 0, 1);  req(0, ADDR_COUNT, 0, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog t=%0t got=running expected=finished", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus.i_cyc = 0; bus.i_stb = 0; bus.i_we = 0; bus.i_addr = '0; bus.i_data = '0;
    repeat (3) @(posedge i_clk);
    #1 i_reset_n = 1;
    chk("rst_led", 32'(o_led), 0);
    chk("rst_ack", 32'(bus.o_ack), 0);
    chk("rst_data", bus.o_data, 0);
    chk("rst_stall", 32'(bus.o_stall), 0);
    read_all();                                   // back-to-back reads
    idle(2);
    // strobe without cycle must be ignored
    bus.i_stb = 1; bus.i_cyc = 0; idle(1); bus.i_stb = 0;

    // bounce once, one position per cycle
    req(1, ADDR_RATE, 0); req(1, ADDR_CTRL, 0); idle(14); read_all();
    // one-way once, RATE=3 (upper bits ignored)
    req(1, ADDR_RATE, 32'hFFFF_FF03); req(1, ADDR_CTRL, 1); idle(34); read_all();
    // continuous, then stop
    req(1, ADDR_RATE, 0); req(1, ADDR_CTRL, 2); idle(30); read_all();
    req(1, ADDR_CTRL, 3); idle(2); read_all();
    // LED write stalls while busy; CTRL/COUNT writes do not
    req(1, ADDR_RATE, 1); req(1, ADDR_CTRL, 0); req(1, ADDR_COUNT, 7);
    req(1, ADDR_CTRL, 0); req(1, ADDR_LED, 32'h2A); idle(2); read_all();
    req(1, ADDR_CTRL, 3); idle(1);
    // count clear coincident with pass completion
    req(1, ADDR_RATE, 0); req(1, ADDR_CTRL, 1); idle(20);
    req(1, ADDR_CTRL, 1); idle(5); req(1, ADDR_COUNT, 0); idle(2); read_all();
    // reset mid-walk with an ack in flight
    req(1, ADDR_RATE, 1); req(1, ADDR_CTRL, 2); idle(7);
    req(0, ADDR_COUNT, 0);
    #1 i_reset_n = 0;
    #1;
    chk("midrst_led", 32'(o_led), 0);
    chk("midrst_ack", 32'(bus.o_ack), 0);
    repeat (2) @(posedge i_clk);
    #1 i_reset_n = 1;
    read_all();

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      int k;
      logic [31:0] d;
      k = $urandom_range(0, 9);
      d = $urandom;
      case (k)
        0, 1, 2: req(1, ADDR_CTRL, d);
        3: req(1, ADDR_RATE, (d & ~32'hFF) | 32'($urandom_range(0, 3)));
        4: if (m_busy && m_mode == 2) req(1, ADDR_CTRL, 3);
           else req(1, ADDR_LED, d);
        5: req(1, ADDR_COUNT, d);
        default: req(0, 2'($urandom_range(0, 3)), d, ($urandom_range(0, 1) == 1));
      endcase
      if (bus.i_stb && $urandom_range(0, 1) == 1) begin
        bus.i_cyc = 0; bus.i_stb = 0; bus.i_we = 0;
      end
      idle($urandom_range(0, 12));
      bus.i_cyc = 0; bus.i_stb = 0; bus.i_we = 0;
    end
    req(1, ADDR_CTRL, 3);
    idle(3);
    read_all();
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
